rf_hs_responder: RTL and testbench

Responder end of the four-phase req/ack register-access handshake used across the asynchronous ARM core. The block accepts read, write and swap commands from an initiator, such as an execute-stage sequencer or bench driver, and performs each one on a private 16×32 register bank. Register 15 acts as the PC. The block returns read data and status with `ack`. It is the counterpart of the initiators that wait on `ack` before issuing each register access.

---
 rtl/rf_hs_pkg.sv | 24 ++
 rtl/rf_hs_bank.sv | 41 ++++
 rtl/rf_hs_responder.sv | 125 ++++++++++++
 tb/tb_rf_hs_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rf_hs_pkg.sv
// rf_hs_pkg: shared encodings and constants for the rf_hs_responder slice.
//   op_e    : command encoding on the op port.
//   state_e : responder FSM states.
//   PC_IDX  : register index that acts as the program counter.
//   PC_STEP : autoincrement step for the PC.
package rf_hs_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SWAP  = 2'b10,
    OP_ILL   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_ACK    = 2'b10
  } state_e;

  localparam logic [3:0] PC_IDX  = 4'd15;
  localparam int         PC_STEP = 4;

endpackage

// File: rtl/rf_hs_bank.sv
// rf_hs_bank: 16 x DATA_W register storage.
//   clk, rst  : clock, asynchronous active-high reset
//   raddr_i   : combinational read address -> rdata_o
//   we_i      : write enable; waddr_i/wdata_i written at the rising edge
//   inc_i     : advance r15 by PC_STEP at the rising edge
//   pc_o      : live r15 value
// A write to r15 in the same edge as inc_i takes priority over the increment.
module rf_hs_bank
  import rf_hs_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  input  logic              we_i,
  input  logic [3:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              inc_i,
  output logic [DATA_W-1:0] pc_o
);

  logic [15:0][DATA_W-1:0] regs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
      regs_q[PC_IDX] <= RESET_PC;
    end else begin
      if (inc_i) regs_q[PC_IDX] <= regs_q[PC_IDX] + DATA_W'(PC_STEP);
      // Last assignment wins, so an explicit write to r15 overrides the step.
      if (we_i)  regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = regs_q[raddr_i];
  assign pc_o    = regs_q[PC_IDX];

endmodule

// File: rtl/rf_hs_responder.sv
// rf_hs_responder: responder side of the four-phase req/ack register-access
// handshake. Executes READ / WRITE / SWAP on a private 16-entry bank.
//   clk, rst : clock, asynchronous active-high reset
//   req      : initiator request (sampled only in IDLE / ACK)
//   op, addr, wdata : command, register index, write data (captured in IDLE)
//   ack      : acknowledge; rdata/err valid while high
//   rdata    : read result (0 for WRITE and illegal op)
//   err      : illegal-op flag
//   busy     : FSM not in IDLE
//   pc       : live r15
// Build option: define RF_HS_PC_AUTOINC_EN to step r15 by 4 on every commit.
module rf_hs_responder
  import rf_hs_pkg::*;
#(
  parameter int                DATA_W        = 32,
  parameter int                ACCESS_CYCLES = 1,
  parameter logic [DATA_W-1:0] RESET_PC      = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [1:0]        op,
  input  logic [3:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic [DATA_W-1:0] pc
);

  state_e            state_q;
  logic [3:0]        cnt_q;
  op_e               op_q;
  logic [3:0]        addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              ack_q;

  logic              commit;
  logic              bank_we;
  logic              bank_inc;
  logic [DATA_W-1:0] bank_rdata;

  // Commit edge: last ACCESS cycle. Bank read is combinational, so SWAP sees
  // the old value here while the write lands at the same edge.
  assign commit  = (state_q == S_ACCESS) && (cnt_q == 4'd0);
  assign bank_we = commit && ((op_q == OP_WRITE) || (op_q == OP_SWAP));

`ifdef RF_HS_PC_AUTOINC_EN
  assign bank_inc = commit;
`else
  assign bank_inc = 1'b0;
`endif

  rf_hs_bank #(
    .DATA_W   (DATA_W),
    .RESET_PC (RESET_PC)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .raddr_i (addr_q),
    .rdata_o (bank_rdata),
    .we_i    (bank_we),
    .waddr_i (addr_q),
    .wdata_i (wdata_q),
    .inc_i   (bank_inc),
    .pc_o    (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            op_q    <= op_e'(op);
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt_q   <= 4'(ACCESS_CYCLES - 1);
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
            case (op_q)
              OP_READ,
              OP_SWAP:  begin rdata_q <= bank_rdata; err_q <= 1'b0; end
              OP_WRITE: begin rdata_q <= '0;         err_q <= 1'b0; end
              default:  begin rdata_q <= '0;         err_q <= 1'b1; end
            endcase
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ACK: begin
          // Holding req keeps us here; a new transaction needs req low first.
          if (!req) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign err   = err_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_rf_hs_responder.sv
// Scoreboard bench for rf_hs_responder: the driver pushes the expected
// response per transaction; a monitor pops on each rising ack and compares.
module tb_rf_hs_responder;

  localparam int          ACC  = 3;
  localparam logic [31:0] RPC  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [3:0]  addr = 4'd0;
  logic [31:0] wdata = '0;
  logic        ack, err, busy;
  logic [31:0] rdata, pc;

  rf_hs_responder #(
    .DATA_W        (32),
    .ACCESS_CYCLES (ACC),
    .RESET_PC      (RPC)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .op    (op),
    .addr  (addr),
    .wdata (wdata),
    .ack   (ack),
    .rdata (rdata),
    .err   (err),
    .busy  (busy),
    .pc    (pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mregs [16];
  int          checks = 0;
  int          errors = 0;
  logic        ack_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    mregs[15] = RPC;
  endtask

  // Reference behaviour of one committed transaction.
  task automatic model_txn(input logic [1:0] o, input logic [3:0] a, input logic [31:0] d);
    exp_t e;
    case (o)
      2'b00:   begin e.rdata = mregs[a]; e.err = 1'b0; end
      2'b01:   begin e.rdata = '0;       e.err = 1'b0; end
      2'b10:   begin e.rdata = mregs[a]; e.err = 1'b0; end
      default: begin e.rdata = '0;       e.err = 1'b1; end
    endcase
`ifdef RF_HS_PC_AUTOINC_EN
    mregs[15] = mregs[15] + 32'd4;
`endif
    if (o == 2'b01 || o == 2'b10) mregs[a] = d;
    e.pc = mregs[15];
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full handshake; hold = extra cycles req stays high after ack.
  task automatic txn(input logic [1:0] o, input logic [3:0] a, input logic [31:0] d, input int hold);
    int n;
    model_txn(o, a, d);
    op = o; addr = a; wdata = d; req = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!ack && n < 64);
    check("ack_latency", n, ACC + 1);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("ack_held", {31'd0, ack}, 32'd1);
    end
    req = 1'b0;
    tick();
    check("ack_fall", {31'd0, ack}, 32'd0);
    check("err_clear", {31'd0, err}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: compare on each rising ack.
  always @(negedge clk) begin
    if (rst) begin
      ack_prev <= 1'b0;
    end else begin
      if (ack && !ack_prev) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_ack", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("rdata", rdata, e.rdata);
          check("err", {31'd0, err}, {31'd0, e.err});
          check("pc", pc, e.pc);
        end
      end
      ack_prev <= ack;
    end
  end

  initial begin
    int n;
    model_reset();
    #12;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_pc", pc, RPC);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Write then read
    txn(2'b01, 4'd0, 32'h2, 0);
    txn(2'b00, 4'd0, 32'h0, 0);
    // Swap
    txn(2'b01, 4'd1, 32'h2, 0);
    txn(2'b10, 4'd1, 32'h4, 0);
    txn(2'b00, 4'd1, 32'h0, 0);
    // Illegal op leaves r3 alone
    txn(2'b01, 4'd3, 32'h33, 0);
    txn(2'b11, 4'd3, 32'hFFFF_FFFF, 0);
    txn(2'b00, 4'd3, 32'h0, 0);
    // req held 5 cycles past ack: single commit
    txn(2'b10, 4'd7, 32'hDEAD, 5);
    txn(2'b00, 4'd7, 32'h0, 0);

    // req dropped during ACCESS: still commits, one-cycle ack
    model_txn(2'b01, 4'd5, 32'h55);
    op = 2'b01; addr = 4'd5; wdata = 32'h55; req = 1'b1;
    tick();
    req = 1'b0;
    n = 1;
    while (!ack && n < 64) begin tick(); n++; end
    check("drop_latency", n, ACC + 1);
    tick();
    check("drop_ack_one_cycle", {31'd0, ack}, 32'd0);
    check("drop_busy", {31'd0, busy}, 32'd0);
    txn(2'b00, 4'd5, 32'h0, 0);

    // Reset mid-ACCESS aborts WRITE r2
    op = 2'b01; addr = 4'd2; wdata = 32'hAB; req = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_ack", {31'd0, ack}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_pc", pc, RPC);
    model_reset();
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    txn(2'b00, 4'd2, 32'h0, 0);

    // PC behaviour
    txn(2'b01, 4'd15, 32'hFFFF_FFFC, 0);
    check("pc_written", pc, 32'hFFFF_FFFC);
    txn(2'b00, 4'd0, 32'h0, 0);
`ifdef RF_HS_PC_AUTOINC_EN
    check("pc_wrap", pc, 32'h0);
`else
    check("pc_static", pc, 32'hFFFF_FFFC);
`endif
    txn(2'b01, 4'd15, 32'h100, 0);
    check("pc_write_wins", pc, 32'h100);
    txn(2'b00, 4'd15, 32'h0, 0);

    repeat (2) tick();
    check("sb_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
